// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Bundle of the pipeline-facing signals of hazard_ctrl.
//                The slave side is the hazard controller. The master side is
//                the pipeline (decoder, EX stage, WB stage, board I/O).
//  Signals     : id_rs/id_rt/id_r1_used/id_r2_used - ID register use
//                ex_mem_to_reg/ex_reg_write/ex_dest - EX write-back info
//                ex_redirect - taken branch/jump resolved in EX
//                wb_halt/go  - syscall halt and resume request
//                cnt_clr     - clear all performance counters
//                stall/flush_if_id/flush_id_ex - pipeline control (comb.)
//                halted, cycle_cnt, stall_cnt, flush_cnt - registered status
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_r1_used;
  logic             id_r2_used;
  logic             ex_mem_to_reg;
  logic             ex_reg_write;
  logic [4:0]       ex_dest;
  logic             ex_redirect;
  logic             wb_halt;
  logic             go;
  logic             cnt_clr;
  logic             stall;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_rs, id_rt, id_r1_used, id_r2_used,
    input  ex_mem_to_reg, ex_reg_write, ex_dest, ex_redirect,
    input  wb_halt, go, cnt_clr,
    output stall, flush_if_id, flush_id_ex,
    output halted, cycle_cnt, stall_cnt, flush_cnt
  );

  modport master (
    output id_rs, id_rt, id_r1_used, id_r2_used,
    output ex_mem_to_reg, ex_reg_write, ex_dest, ex_redirect,
    output wb_halt, go, cnt_clr,
    input  stall, flush_if_id, flush_id_ex,
    input  halted, cycle_cnt, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard and halt controller for the 5-stage MIPS pipeline.
//                Detects load-use hazards, turns EX redirects into flushes,
//                runs the syscall halt/resume state machine and keeps
//                saturating performance counters.
//  Ports       : clk   - system clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - hazard_ctrl_if.slave, pipeline signals and status
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic             w_lu;
  logic             w_redirect_case;
  logic             w_lu_case;
  logic             w_stall;
  logic             w_flush_if_id;
  logic             w_flush_id_ex;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // A load to r0 never creates a dependency since r0 is hard-wired to zero.
  always_comb begin
    w_lu = bus.ex_mem_to_reg & bus.ex_reg_write & (bus.ex_dest != 5'd0) &
           ((bus.id_r1_used & (bus.id_rs == bus.ex_dest)) |
            (bus.id_r2_used & (bus.id_rt == bus.ex_dest)));
  end

  // Redirect wins over load-use: the ID instruction is wrong-path anyway.
  always_comb begin
    w_redirect_case = (r_state == ST_RUN) & bus.ex_redirect;
    w_lu_case       = (r_state == ST_RUN) & ~bus.ex_redirect & w_lu;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and the zero-latency pipeline controls.
  always_comb begin
    w_next        = r_state;
    w_stall       = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;

    case (r_state)
      ST_RUN:  if (bus.wb_halt) w_next = ST_HALT;
      ST_HALT: if (bus.go)      w_next = ST_RUN;
      default: w_next = ST_RUN;
    endcase

    if (!rst_n) begin
      w_flush_if_id = 1'b1;
      w_flush_id_ex = 1'b1;
    end else if (r_state == ST_HALT) begin
      // Hold fetch, keep bubbling EX so older instructions drain.
      w_stall       = 1'b1;
      w_flush_id_ex = 1'b1;
    end else if (w_redirect_case) begin
      w_flush_if_id = 1'b1;
      w_flush_id_ex = 1'b1;
    end else if (w_lu_case) begin
      w_stall       = 1'b1;
      w_flush_id_ex = 1'b1;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == C_CNT_MAX) ? v : v + C_CNT_ONE;
  endfunction

  // Counters: reset, then clear, then increment. Nothing counts in HALT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle_cnt <= C_CNT_ZERO;
      r_stall_cnt <= C_CNT_ZERO;
      r_flush_cnt <= C_CNT_ZERO;
    end else if (bus.cnt_clr) begin
      r_cycle_cnt <= C_CNT_ZERO;
      r_stall_cnt <= C_CNT_ZERO;
      r_flush_cnt <= C_CNT_ZERO;
    end else begin
      if (r_state == ST_RUN) r_cycle_cnt <= sat_inc(r_cycle_cnt);
      if (w_lu_case)         r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_redirect_case)   r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign bus.stall       = w_stall;
  assign bus.flush_if_id = w_flush_if_id;
  assign bus.flush_id_ex = w_flush_id_ex;
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.cycle_cnt   = r_cycle_cnt;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed self-checking bench for hazard_ctrl (CNT_W=4 so
//                counter saturation is reachable quickly).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  hazard_ctrl_if #(.CNT_W(4)) bus ();

  hazard_ctrl #(.CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.id_rs = 5'd0;  bus.id_rt = 5'd0;
    bus.id_r1_used = 1'b0; bus.id_r2_used = 1'b0;
    bus.ex_mem_to_reg = 1'b0; bus.ex_reg_write = 1'b0;
    bus.ex_dest = 5'd0; bus.ex_redirect = 1'b0;
    bus.wb_halt = 1'b0; bus.go = 1'b0; bus.cnt_clr = 1'b0;
  endtask

  task automatic ctl(input string tag, input logic s, input logic fi, input logic fe);
    #1;
    chk({tag, ".stall"},       32'(bus.stall),       32'(s));
    chk({tag, ".flush_if_id"}, 32'(bus.flush_if_id), 32'(fi));
    chk({tag, ".flush_id_ex"}, 32'(bus.flush_id_ex), 32'(fe));
  endtask

  task automatic cnts(input string tag, input int h, input int c, input int s, input int f);
    chk({tag, ".halted"},    32'(bus.halted),    h);
    chk({tag, ".cycle_cnt"}, 32'(bus.cycle_cnt), c);
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), s);
    chk({tag, ".flush_cnt"}, 32'(bus.flush_cnt), f);
  endtask

  task automatic set_lu;
    bus.ex_mem_to_reg = 1'b1; bus.ex_reg_write = 1'b1;
    bus.ex_dest = 5'd8; bus.id_rs = 5'd8; bus.id_r1_used = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idle_inputs();

    // Reset: combinational controls follow the reset case.
    ctl("rst_comb", 1'b0, 1'b1, 1'b1);
    tick();
    cnts("rst_state", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Load-use on rs.
    set_lu();
    ctl("lu_rs", 1'b1, 1'b0, 1'b1);
    tick();
    cnts("lu_rs", 0, 1, 1, 0);

    // Load into r0 is not a hazard.
    bus.ex_dest = 5'd0; bus.id_rs = 5'd0;
    ctl("lu_r0", 1'b0, 1'b0, 1'b0);
    tick();
    cnts("lu_r0", 0, 2, 1, 0);

    // rs matches but is not read.
    bus.ex_dest = 5'd8; bus.id_rs = 5'd8; bus.id_r1_used = 1'b0;
    ctl("lu_unused", 1'b0, 1'b0, 1'b0);
    tick();
    cnts("lu_unused", 0, 3, 1, 0);

    // Load-use on rt.
    bus.id_rs = 5'd3; bus.id_r1_used = 1'b1;
    bus.id_rt = 5'd8; bus.id_r2_used = 1'b1;
    ctl("lu_rt", 1'b1, 1'b0, 1'b1);
    tick();
    cnts("lu_rt", 0, 4, 2, 0);

    // Redirect beats load-use.
    bus.ex_redirect = 1'b1;
    ctl("redir_lu", 1'b0, 1'b1, 1'b1);
    tick();
    cnts("redir_lu", 0, 5, 2, 1);

    // Load that does not write a register is not a hazard.
    bus.ex_redirect = 1'b0; bus.ex_reg_write = 1'b0;
    ctl("lu_nowr", 1'b0, 1'b0, 1'b0);
    tick();
    cnts("lu_nowr", 0, 6, 2, 1);

    // Clear in the same cycle as a lu stall wins.
    idle_inputs();
    set_lu();
    bus.cnt_clr = 1'b1;
    ctl("clr_lu", 1'b1, 1'b0, 1'b1);
    tick();
    cnts("clr_lu", 0, 0, 0, 0);

    // Lone redirect.
    idle_inputs();
    bus.ex_redirect = 1'b1;
    ctl("redir", 1'b0, 1'b1, 1'b1);
    tick();
    cnts("redir", 0, 1, 0, 1);

    // Halt: wb_halt at this edge, halted and stall from the next cycle.
    idle_inputs();
    bus.wb_halt = 1'b1;
    tick();
    cnts("halt_enter", 1, 2, 0, 1);
    bus.wb_halt = 1'b0;
    ctl("halt_comb", 1'b1, 1'b0, 1'b1);

    // In HALT, redirect/lu/wb_halt are ignored and counters freeze.
    set_lu();
    bus.ex_redirect = 1'b1;
    bus.wb_halt = 1'b1;
    ctl("halt_prio", 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    cnts("halt_frozen", 1, 2, 0, 1);
    idle_inputs();

    // Resume: halted drops after the go edge, next RUN cycle is counted.
    bus.go = 1'b1;
    tick();
    cnts("go", 0, 2, 0, 1);
    bus.go = 1'b0;
    ctl("go_comb", 1'b0, 1'b0, 1'b0);
    tick();
    cnts("run_after_go", 0, 3, 0, 1);

    // go in RUN is ignored.
    bus.go = 1'b1;
    tick();
    cnts("go_in_run", 0, 4, 0, 1);

    // go with wb_halt in RUN: halt wins.
    bus.wb_halt = 1'b1;
    tick();
    cnts("halt_and_go", 1, 5, 0, 1);
    idle_inputs();
    tick();
    cnts("halt_hold", 1, 5, 0, 1);

    // Reset while halted.
    rst_n = 1'b0;
    ctl("rst_in_halt", 1'b0, 1'b1, 1'b1);
    tick();
    cnts("rst_in_halt", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Saturation at 15 with CNT_W=4.
    for (int i = 0; i < 20; i++) tick();
    cnts("sat", 0, 15, 0, 0);
    bus.cnt_clr = 1'b1;
    tick();
    cnts("sat_clr", 0, 0, 0, 0);
    bus.cnt_clr = 1'b0;
    tick();
    tick();
    cnts("after_clr", 0, 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
